// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous-read RAM between the fetch port and the load/store port.
// Latency: grant and RAM drive in cycle N, ready pulse in N+1, for reads, writes and out-of-window data accesses.
// Backpressure: requesters hold req until ready; ties alternate round-robin; a requester is masked during its own ready cycle.
module mem_arbiter #(
  parameter int XLEN  = 32,
  parameter int AW    = XLEN - 2,
  parameter int DEPTH = 4096
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_ready,
  output logic [XLEN-1:0] i_data,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_ready,
  output logic [XLEN-1:0] d_rdata,
  output logic            ram_en,
  output logic            ram_we,
  output logic [AW-1:0]   ram_addr,
  output logic [XLEN-1:0] ram_wdata,
  input  logic [XLEN-1:0] ram_rdata
);

  // One extra bit so a DEPTH equal to 2**AW still compares correctly.
  localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(DEPTH);

  // In-flight tag: which access (if any) completes in the current cycle.
  typedef enum logic [1:0] {
    IDLE,
    I_WAIT,
    D_WAIT,
    D_OOR
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   rr_last;     // 1 = data port was granted most recently
  logic   i_elig;
  logic   d_elig;
  logic   grant_i;
  logic   grant_d;
  logic   d_in_range;

  // Eligibility mask, round-robin grant and RAM drive; reset blocks every grant.
  always_comb begin
    i_elig     = i_req && (state != I_WAIT);
    d_elig     = d_req && (state != D_WAIT) && (state != D_OOR);
    grant_i    = reset && i_elig && (!d_elig || rr_last);
    grant_d    = reset && d_elig && (!i_elig || !rr_last);
    d_in_range = ({1'b0, d_addr} < DEPTH_LIM);
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    state_nxt  = IDLE;
    if (grant_i) begin
      ram_en    = 1'b1;
      ram_addr  = i_addr;
      state_nxt = I_WAIT;
    end else if (grant_d) begin
      if (d_in_range) begin
        ram_en    = 1'b1;
        ram_we    = d_we;
        ram_addr  = d_addr;
        ram_wdata = d_wdata;
        state_nxt = D_WAIT;
      end else begin
        // MMIO/halt window: complete without touching the RAM.
        state_nxt = D_OOR;
      end
    end
  end

  // Advance the in-flight tag and remember who won the last grant.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      rr_last <= 1'b1;
    end else begin
      state <= state_nxt;
      if (grant_i) begin
        rr_last <= 1'b0;
      end else if (grant_d) begin
        rr_last <= 1'b1;
      end
    end
  end

  // Ready pulses decode the registered tag; read data passes straight from the RAM.
  always_comb begin
    i_ready = (state == I_WAIT);
    d_ready = (state == D_WAIT) || (state == D_OOR);
    i_data  = ram_rdata;
    d_rdata = (state == D_OOR) ? '0 : ram_rdata;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous-read RAM model.
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
// Each directed step states its hand-computed expected values.
module tb_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        i_req;
  logic [29:0] i_addr;
  logic        i_ready;
  logic [31:0] i_data;
  logic        d_req;
  logic        d_we;
  logic [29:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        ram_en;
  logic        ram_we;
  logic [29:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:255];
  logic        mem_init = 1'b0;

  mem_arbiter #(.XLEN(32), .AW(30), .DEPTH(4096)) dut (
    .clock     (clock),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ready   (i_ready),
    .i_data    (i_data),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ready   (d_ready),
    .d_rdata   (d_rdata),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-port synchronous-read RAM model; word 0x10 preloaded with 0x00000013.
  always @(posedge clock) begin
    if (!mem_init) begin
      mem[8'h10] <= 32'h0000_0013;
      mem_init   <= 1'b1;
    end
    if (ram_en) begin
      if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr[7:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  initial begin
    reset   = 1'b0;
    i_req   = 1'b0;
    i_addr  = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;

    // Reset held low with a pending fetch: RAM must stay disabled.
    next_cycle();
    i_req = 1'b1; i_addr = 30'h10;
    sample();
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    next_cycle();
    sample();
    chk("rst_i_ready", i_ready, 0);
    chk("rst_d_ready", d_ready, 0);
    chk("rst_ram_en2", ram_en, 0);

    // Fetch only: grant c0, ready c1 (masked), grant again c2.
    next_cycle();
    reset = 1'b1;
    sample();
    chk("f0_ram_en", ram_en, 1);
    chk("f0_ram_we", ram_we, 0);
    chk("f0_ram_addr", ram_addr, 32'h10);
    chk("f0_i_ready", i_ready, 0);
    next_cycle();
    sample();
    chk("f1_i_ready", i_ready, 1);
    chk("f1_i_data", i_data, 32'h0000_0013);
    chk("f1_ram_en", ram_en, 0);
    next_cycle();
    sample();
    chk("f2_ram_en", ram_en, 1);
    chk("f2_i_ready", i_ready, 0);
    next_cycle();
    i_req = 1'b0;
    sample();
    chk("f3_i_ready", i_ready, 1);
    chk("f3_ram_en", ram_en, 0);

    // Store 0xDEADBEEF to 0x20, then load it back.
    next_cycle();
    d_req = 1'b1; d_we = 1'b1; d_addr = 30'h20; d_wdata = 32'hDEAD_BEEF;
    sample();
    chk("st_ram_en", ram_en, 1);
    chk("st_ram_we", ram_we, 1);
    chk("st_ram_addr", ram_addr, 32'h20);
    chk("st_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
    chk("st_d_ready0", d_ready, 0);
    next_cycle();
    sample();
    chk("st_d_ready1", d_ready, 1);
    chk("st_masked", ram_en, 0);
    next_cycle();
    d_we = 1'b0;
    sample();
    chk("ld_ram_en", ram_en, 1);
    chk("ld_ram_we", ram_we, 0);
    chk("ld_d_ready0", d_ready, 0);
    next_cycle();
    d_req = 1'b0;
    sample();
    chk("ld_d_ready1", d_ready, 1);
    chk("ld_d_rdata", d_rdata, 32'hDEAD_BEEF);

    // Contention after reset: I, D, I, D with the RAM busy every cycle.
    next_cycle();
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    i_req = 1'b1; i_addr = 30'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 30'h20;
    sample();
    chk("c0_ram_en", ram_en, 1);
    chk("c0_addr_i", ram_addr, 32'h10);
    chk("c0_i_ready", i_ready, 0);
    chk("c0_d_ready", d_ready, 0);
    next_cycle();
    sample();
    chk("c1_ram_en", ram_en, 1);
    chk("c1_addr_d", ram_addr, 32'h20);
    chk("c1_i_ready", i_ready, 1);
    chk("c1_d_ready", d_ready, 0);
    chk("c1_i_data", i_data, 32'h0000_0013);
    next_cycle();
    sample();
    chk("c2_ram_en", ram_en, 1);
    chk("c2_addr_i", ram_addr, 32'h10);
    chk("c2_i_ready", i_ready, 0);
    chk("c2_d_ready", d_ready, 1);
    chk("c2_d_rdata", d_rdata, 32'hDEAD_BEEF);
    next_cycle();
    sample();
    chk("c3_ram_en", ram_en, 1);
    chk("c3_addr_d", ram_addr, 32'h20);
    chk("c3_i_ready", i_ready, 1);
    next_cycle();
    i_req = 1'b0; d_req = 1'b0;
    sample();
    chk("c4_d_ready", d_ready, 1);
    chk("c4_i_ready", i_ready, 0);
    chk("c4_ram_en", ram_en, 0);

    // Out-of-range store, then load from the same address returns 0.
    next_cycle();
    d_req = 1'b1; d_we = 1'b1; d_addr = 30'h0800_0000; d_wdata = 32'h1234_5678;
    sample();
    chk("oor_st_ram_en", ram_en, 0);
    chk("oor_st_ram_we", ram_we, 0);
    chk("oor_st_d_ready0", d_ready, 0);
    next_cycle();
    sample();
    chk("oor_st_d_ready1", d_ready, 1);
    chk("oor_st_masked", ram_en, 0);
    next_cycle();
    d_we = 1'b0;
    sample();
    chk("oor_ld_ram_en", ram_en, 0);
    next_cycle();
    d_req = 1'b0;
    sample();
    chk("oor_ld_d_ready", d_ready, 1);
    chk("oor_ld_d_rdata", d_rdata, 0);

    // Window edge: 0x1000 is outside, 0xFFF is the last RAM word.
    next_cycle();
    d_req = 1'b1; d_we = 1'b0; d_addr = 30'h1000;
    sample();
    chk("edge_depth_en", ram_en, 0);
    next_cycle();
    d_addr = 30'hFFF;
    sample();
    chk("edge_depth_ready", d_ready, 1);
    chk("edge_depth_rdata", d_rdata, 0);
    next_cycle();
    sample();
    chk("edge_last_en", ram_en, 1);
    chk("edge_last_addr", ram_addr, 32'hFFF);
    next_cycle();
    d_req = 1'b0;
    sample();
    chk("edge_last_ready", d_ready, 1);

    // Reset mid-flight: fetch granted, reset sampled at the end of that cycle.
    next_cycle();
    i_req = 1'b1; i_addr = 30'h10;
    sample();
    chk("mf0_ram_en", ram_en, 1);
    #1 reset = 1'b0;
    next_cycle();
    d_req = 1'b1; d_we = 1'b0; d_addr = 30'h20;
    sample();
    chk("mf1_i_ready", i_ready, 0);
    chk("mf1_d_ready", d_ready, 0);
    chk("mf1_ram_en", ram_en, 0);
    next_cycle();
    reset = 1'b1;
    sample();
    chk("mf2_tie_to_i", ram_addr, 32'h10);
    chk("mf2_ram_en", ram_en, 1);
    chk("mf2_i_ready", i_ready, 0);
    next_cycle();
    sample();
    chk("mf3_i_ready", i_ready, 1);
    chk("mf3_addr_d", ram_addr, 32'h20);
    i_req = 1'b0; d_req = 1'b0;

    next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one single-port, synchronous-read word RAM between the CPU instruction-fetch port and the data load/store port. Sits between `cpu` and a single-port `ram` and replaces the dual-port `ram_dp` in area-constrained builds. Requests use a hold-until-ready handshake, ties are resolved round-robin, and data accesses outside the RAM window complete without touching the RAM.

## Interface
Parameters:
- `XLEN`, 32, data width and full byte-address width.
- `AW`, `XLEN - 2`, word-address width; ports carry word addresses.
- `DEPTH`, 4096, RAM depth in words; valid word addresses are 0..DEPTH-1.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the rising edge of `clock`.
- `i_req`  in  1  instruction fetch request; held with `i_addr` stable until `i_ready`.
- `i_addr`  in  AW  fetch word address.
- `i_ready`  out  1  one-cycle pulse; fetch complete, `i_data` valid this cycle.
- `i_data`  out  XLEN  fetched word.
- `d_req`  in  1  data request; held with `d_we`, `d_addr` and `d_wdata` stable until `d_ready`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  AW  data word address.
- `d_wdata`  in  XLEN  store data.
- `d_ready`  out  1  one-cycle pulse; data access complete, `d_rdata` valid this cycle for loads.
- `d_rdata`  out  XLEN  load data.
- `ram_en`  out  1  RAM access enable.
- `ram_we`  out  1  RAM write enable; only asserted with `ram_en`.
- `ram_addr`  out  AW  RAM word address.
- `ram_wdata`  out  XLEN  RAM write data.
- `ram_rdata`  in  XLEN  RAM read data; valid the cycle after `ram_en` with `ram_we`=0.

## Operation
- States (registered in-flight tag): IDLE, I_WAIT, D_WAIT, D_OOR.
- Eligible requesters in cycle N: `i_req`, unless state is I_WAIT; `d_req`, unless state is D_WAIT or D_OOR. This mask blocks re-granting a requester whose `req` is still high during its ready cycle.
- Grant when one requester is eligible: that requester. When both are eligible: the one not granted last (`rr_last`). `rr_last` updates on every grant.
- Fetch grant: `ram_en`=1, `ram_we`=0, `ram_addr`=`i_addr`; next state I_WAIT.
- Data grant with `d_addr` < DEPTH: `ram_en`=1, `ram_we`=`d_we`, `ram_addr`=`d_addr`, `ram_wdata`=`d_wdata`; next state D_WAIT.
- Data grant with `d_addr` >= DEPTH (MMIO/halt region): `ram_en`=0, `ram_we`=0; next state D_OOR. Stores are dropped. Loads return 0.
- No grant: `ram_en`=0, `ram_we`=0; next state IDLE.
- I_WAIT: `i_ready`=1, `i_data`=`ram_rdata`. D_WAIT: `d_ready`=1, `d_rdata`=`ram_rdata` (don't-care for stores). D_OOR: `d_ready`=1, `d_rdata`=0.
- A new grant may issue in the same cycle as a ready pulse. This is the in-flight state's successor transition.
- `i_data` and `d_rdata` are combinational from `ram_rdata` and are defined only while their ready is high.
- Address comparison is unsigned, at full AW width.

## Timing
- Grant and RAM drive are combinational in cycle N. Ready is registered and pulses in cycle N+1. Latency is 1 cycle from the grant cycle for reads, writes and OOR accesses.
- With both requesters continuously requesting, grants alternate I, D, I, D. RAM utilisation is 100%, and each requester gets at most one access every 2 cycles.
- A lone requester gets one access every 2 cycles, because it is masked during its own ready cycle.
- Reset (`reset`=0 at an edge): state IDLE; `rr_last`=data, so the first tie goes to fetch; `i_ready`=0, `d_ready`=0.
- While `reset` is low, `ram_en`=0 and `ram_we`=0 combinationally. An in-flight access is abandoned and no ready pulse is issued for it.
- Outputs are valid from the first edge after `reset` is sampled low.

## Test plan
- Fetch only: `i_req`=1, `i_addr`=0x10, RAM[0x10]=0x00000013 -> `ram_en`=1 in cycle 0; `i_ready`=1 and `i_data`=0x00000013 in cycle 1; no grant in cycle 1; next grant in cycle 2.
- Store then load: store 0xDEADBEEF to `d_addr`=0x20, then load 0x20 -> `d_ready` pulses in cycles 1 and 3; the load returns 0xDEADBEEF.
- Contention after reset: `i_req`=`d_req`=1 held -> grant order I, D, I, D; `i_ready` high in cycles 1 and 3, `d_ready` high in cycles 2 and 4; `ram_en` high in every cycle.
- Out-of-range: DEPTH=4096, store to `d_addr`=0x08000000 (byte address 0x20000000) -> `ram_en`=0, `ram_we`=0, `d_ready`=1 in the next cycle; a load from the same address returns 0.
- Reset mid-flight: fetch granted in cycle 0 and `reset`=0 sampled at the end of cycle 0 -> `i_ready`=0 in cycle 1 and `ram_en`=0 while reset is low; after release, a tie is granted to fetch first.
